// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO: 5-cycle multiply, 10-cycle divide.
// Optional MDU_TRACE_EN prints one line per HI/LO write.
module mdu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam logic [3:0] MulLatency = 4'd5;
  localparam logic [3:0] DivLatency = 4'd10;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      r_state;
  logic [3:0]  r_count;
  logic        r_busy;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_pend_hi, r_pend_lo;
  logic        r_pend_wr;
  logic [31:0] r_pc;

  logic signed [63:0] w_mul_s;
  logic        [63:0] w_mul_u;
  logic               w_rt_zero;
  logic               w_div_ovf;
  logic signed [31:0] w_num_s, w_den_s, w_quo_s, w_rem_s;
  logic        [31:0] w_den_u, w_quo_u, w_rem_u;

  always_comb begin
    w_mul_s   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    w_mul_u   = {32'd0, rs_data} * {32'd0, rt_data};
    w_rt_zero = (rt_data == 32'd0);
    w_div_ovf = (rs_data == 32'h8000_0000) && (rt_data == 32'hffff_ffff);
    // Dividing by 1 yields the required result for the overflow case and keeps div-by-zero defined.
    w_num_s   = $signed(rs_data);
    w_den_s   = (w_rt_zero || w_div_ovf) ? 32'sd1 : $signed(rt_data);
    w_quo_s   = w_num_s / w_den_s;
    w_rem_s   = w_num_s % w_den_s;
    w_den_u   = w_rt_zero ? 32'd1 : rt_data;
    w_quo_u   = rs_data / w_den_u;
    w_rem_u   = rs_data % w_den_u;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_count   <= 4'd0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_pc      <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            case (op)
              OpMult, OpMultu: begin
                {r_pend_hi, r_pend_lo} <= (op == OpMult) ? w_mul_s : w_mul_u;
                r_pend_wr <= 1'b1;
                r_count   <= MulLatency;
                r_busy    <= 1'b1;
                r_state   <= StBusy;
                r_pc      <= pc;
              end
              OpDiv, OpDivu: begin
                r_pend_lo <= (op == OpDiv) ? w_quo_s : w_quo_u;
                r_pend_hi <= (op == OpDiv) ? w_rem_s : w_rem_u;
                r_pend_wr <= ~w_rt_zero;
                r_count   <= DivLatency;
                r_busy    <= 1'b1;
                r_state   <= StBusy;
                r_pc      <= pc;
              end
              OpMthi: begin
                r_hi <= rs_data;
`ifdef MDU_TRACE_EN
                $display("@%h: $hi <= %h", pc, rs_data);
`endif
              end
              OpMtlo: begin
                r_lo <= rs_data;
`ifdef MDU_TRACE_EN
                $display("@%h: $lo <= %h", pc, rs_data);
`endif
              end
              default: ;
            endcase
          end
        end
        StBusy: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
`ifdef MDU_TRACE_EN
              $display("@%h: $hi <= %h", r_pc, r_pend_hi);
              $display("@%h: $lo <= %h", r_pc, r_pend_lo);
`endif
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifndef MDU_TRACE_EN
  // The captured pc only feeds the trace.
  logic w_unused_pc;
  assign w_unused_pc = ^r_pc;
`endif

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized self-checking bench for mdu_unit against a longint arithmetic model of HI/LO.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, pc;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;

  mdu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .pc     (pc),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hffff_ffff;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is at a negedge; returns at a negedge one cycle after the commit (or the accept).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    logic [31:0] old_hi, old_lo;
    longint x, y, q, r;
    int lat;
    old_hi = m_hi;
    old_lo = m_lo;
    lat = 0;
    case (o)
      3'd1: begin
        x = longint'($signed(a)); y = longint'($signed(b)); q = x * y;
        m_hi = q[63:32]; m_lo = q[31:0]; lat = 5;
      end
      3'd2: begin
        x = {32'd0, a}; y = {32'd0, b}; q = x * y;
        m_hi = q[63:32]; m_lo = q[31:0]; lat = 5;
      end
      3'd3, 3'd4: begin
        lat = 10;
        if (b != 0) begin
          x = (o == 3'd3) ? longint'($signed(a)) : longint'({32'd0, a});
          y = (o == 3'd3) ? longint'($signed(b)) : longint'({32'd0, b});
          q = x / y; r = x % y;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
    start = 1'b1; op = o; rs_data = a; rt_data = b; pc = $urandom;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
    for (int i = 0; i < lat; i++) begin
      check_eq("busy_during", {63'd0, busy}, 64'd1);
      check_eq("hi_during", {32'd0, hi}, {32'd0, old_hi});
      check_eq("lo_during", {32'd0, lo}, {32'd0, old_lo});
      if (noise) begin
        start = 1'($urandom_range(0, 1)); op = 3'($urandom); rs_data = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("busy_after", {63'd0, busy}, 64'd0);
    check_eq("hi_after", {32'd0, hi}, {32'd0, m_hi});
    check_eq("lo_after", {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0; pc = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_hi", {32'd0, hi}, 64'd0);
    check_eq("reset_lo", {32'd0, lo}, 64'd0);

    run_op(3'd1, 32'hffff_ffff, 32'h0000_0002, 1'b0);
    check_eq("mult_hi_const", {32'd0, hi}, 64'hffff_ffff);
    check_eq("mult_lo_const", {32'd0, lo}, 64'hffff_fffe);
    run_op(3'd2, 32'hffff_ffff, 32'h0000_0002, 1'b0);
    check_eq("multu_hi_const", {32'd0, hi}, 64'h0000_0001);
    run_op(3'd3, 32'hffff_fff9, 32'h0000_0002, 1'b1);
    check_eq("div_lo_const", {32'd0, lo}, 64'hffff_fffd);
    check_eq("div_hi_const", {32'd0, hi}, 64'hffff_ffff);
    run_op(3'd3, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    check_eq("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check_eq("div_ovf_hi", {32'd0, hi}, 64'd0);
    run_op(3'd5, 32'h1111_1111, 32'd0, 1'b0);
    run_op(3'd6, 32'h2222_2222, 32'd0, 1'b0);
    run_op(3'd4, 32'd7, 32'd0, 1'b0);
    check_eq("divu0_hi", {32'd0, hi}, 64'h1111_1111);
    check_eq("divu0_lo", {32'd0, lo}, 64'h2222_2222);
    run_op(3'd1, 32'd3, 32'd4, 1'b0);
    run_op(3'd1, 32'hffff_fffd, 32'd5, 1'b0);
    check_eq("b2b_lo", {32'd0, lo}, 64'hffff_fff1);
    run_op(3'd0, 32'h5555_5555, 32'd0, 1'b0);
    run_op(3'd7, 32'h6666_6666, 32'd0, 1'b0);

    // MTHI issued while busy must be ignored, then reset aborts the multiply.
    start = 1'b1; op = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    op = 3'd5; rs_data = 32'hdead_beef;
    @(negedge clk);
    start = 1'b0;
    check_eq("mthi_ignored", {32'd0, hi}, {32'd0, m_hi});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    repeat (8) @(negedge clk);
    check_eq("no_commit_hi", {32'd0, hi}, 64'd0);
    check_eq("no_commit_lo", {32'd0, lo}, 64'd0);
    check_eq("no_commit_busy", {63'd0, busy}, 64'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b0; op = 3'($urandom); rs_data = $urandom;
        @(negedge clk);
        check_eq("idle_hi", {32'd0, hi}, {32'd0, m_hi});
        check_eq("idle_lo", {32'd0, lo}, {32'd0, m_lo});
      end
      run_op(3'($urandom), rand_word(), rand_word(), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have input clk, 1 bit: clock; every state change occurs on its rising edge.
REQ-002 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have input start, 1 bit: the E-stage instruction is an MDU operation this cycle.
REQ-004 SHALL have input op, 3 bits, encoded as: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; code 7 is treated as NONE.
REQ-005 SHALL have input rs_data, 32 bits: forwarded rs operand from the register file path.
REQ-006 SHALL have input rt_data, 32 bits: forwarded rt operand from the register file path.
REQ-007 SHALL have input pc, 32 bits: address of the E-stage instruction, used only for tracing.
REQ-008 SHALL have output busy, 1 bit: a multiply or divide is in progress.
REQ-009 SHALL have output hi, 32 bits: architectural HI register (read by MFHI).
REQ-010 SHALL have output lo, 32 bits: architectural LO register (read by MFLO).

Function
REQ-011 SHALL sample start/op/rs_data/rt_data on the rising edge only when busy=0 and reset=0; when busy=1 all of these inputs SHALL be ignored, including MTHI/MTLO.
REQ-012 SHALL, on an accepted MULT, compute the signed 64-bit product rs*rt; an accepted MULTU SHALL compute the unsigned product; the result is committed as HI=[63:32], LO=[31:0].
REQ-013 SHALL, on an accepted DIV, compute the signed quotient and remainder truncated toward zero; an accepted DIVU SHALL compute the unsigned ones; the result is committed as LO=quotient, HI=remainder.
REQ-014 SHALL, for DIV/DIVU with rt_data=0, run the full latency and leave HI and LO unchanged.
REQ-015 SHALL, for DIV with 0x80000000 / 0xFFFFFFFF, commit LO=0x80000000 and HI=0x00000000.
REQ-016 SHALL latch the result into internal pending registers at the accept edge; hi and lo SHALL hold their old values until the commit edge.
REQ-017 SHALL implement the states IDLE and BUSY with a 4-bit down-counter: accept MULT/MULTU -> BUSY with count 5; accept DIV/DIVU -> BUSY with count 10; each edge in BUSY decrements count; the edge at which count goes 1->0 commits HI/LO and returns to IDLE.
REQ-018 SHALL drive busy=1 for exactly 5 cycles (multiply) or 10 cycles (divide), starting in the cycle after the accept edge; busy SHALL be 0 in the cycle after the commit edge.
REQ-019 SHALL accept a new start in the first cycle after commit (back-to-back); the state SHALL not pass through any extra idle cycle.
REQ-020 SHALL, on an accepted MTHI, write HI=rs_data at that edge with no busy assertion; an accepted MTLO SHALL write LO=rs_data at that edge.
REQ-021 SHALL ignore start=1 with op NONE or 7, and SHALL ignore op whenever start=0.
REQ-022 SHALL produce hi and lo directly from registers, with no combinational path from the inputs.

Reset
REQ-023 SHALL, with reset=1 at an edge, set hi=0, lo=0, busy=0, count=0, state IDLE, and clear the pending registers.
REQ-024 SHALL abort any operation in progress when reset is asserted mid-operation: no commit occurs, and reset has priority over commit and accept in the same edge.

Configuration
REQ-025 SHALL, with MDU_TRACE_EN defined, print one $display per HI change as "@%h: $hi <= %h" (pc, value) and one per LO change as "@%h: $lo <= %h", both at the commit or MTHI/MTLO edge; the pc printed is the pc captured at accept.
REQ-026 SHALL, without MDU_TRACE_EN, emit no simulation output; functional behaviour SHALL be identical with and without the macro.

Verification
REQ-027 MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-028 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-029 DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; hi/lo unchanged during busy.
REQ-030 DIVU rs=7, rt=0 after MTHI 0x11111111 and MTLO 0x22222222 -> busy high 10 cycles, then hi=0x11111111, lo=0x22222222.
REQ-031 MULT accepted, then MTHI 0xDEADBEEF issued during busy, then reset at busy cycle 3 -> MTHI ignored; after reset hi=0, lo=0, busy=0, and no commit afterwards.
REQ-032 Two MULTs back-to-back (second start in the first cycle after commit) -> busy drops for 1 cycle only (the accept cycle); the second result is committed 5 cycles later.
